datamemory_hs: RTL
==================

# datamemory_hs

Handshaked, parametrised data memory for the RISC-V pipeline's MEM stage: a word-organised array of 2^(DM_ADDRESS-2) 32-bit words with byte-lane writes. Supports the full RV32I load/store set (LB, LH, LW, LBU, LHU, SB, SH, SW) behind a valid/ready request channel, a programmable number of wait states, and a registered response with fault reporting for misaligned or illegal accesses. The hazard unit stalls the pipeline on `req_ready`/`rsp_valid`.

## Interface
- `DM_ADDRESS`, 10: byte-address width; array depth = 2^(DM_ADDRESS-2) words, minimum 3.
- `DATA_W`, 32: data width; fixed at 32, any other value is a elaboration error.
- `WAIT_STATES`, 0: extra cycles between accept and response, 0..15.

- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `MemRead` in 1: load request (from control unit).
- `MemWrite` in 1: store request (from control unit).
- `a` in DM_ADDRESS: byte address (LSBs of ALU result).
- `wd` in DATA_W: store data.
- `Funct3` in 3: instruction bits 14:12.
- `rsp_valid` out 1: one-cycle response pulse.
- `rd` out DATA_W: load data, valid when `rsp_valid`.
- `fault` out 1: access rejected, valid when `rsp_valid`.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT and during reset.
- Accept = `req_valid & req_ready`: latch `a`, `wd`, `Funct3`, `MemRead`, `MemWrite`; load wait counter with WAIT_STATES.
- IDLE/RESP + accept: WAIT_STATES=0 -> RESP, else -> WAIT. RESP without accept -> IDLE. WAIT: decrement counter; at 1 -> RESP.
- Load data in RESP: word = mem[a[DM_ADDRESS-1:2]] including all previously committed stores. LB/LBU select byte a[1:0], sign/zero-extend; LH/LHU select half a[1], sign/zero-extend; LW whole word.
- Store commits at the clock edge ending the RESP cycle, using byte enables: SB lane a[1:0], SH lanes {1,0} or {3,2} by a[1], SW all four. Unaddressed lanes unchanged (no read-modify-write).
- Fault (rd=0, no write): LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0; Funct3 in {011,110,111} for loads, or not in {000,001,010} for stores; MemRead and MemWrite both 1; both 0.
- `rd` = 0 on stores and whenever `rsp_valid`=0.
- No response backpressure: consumer samples `rsp_valid` every cycle.
- Memory contents are not initialised or cleared by `reset`.

## Timing
- Reset: state IDLE, counter 0, `rsp_valid`=0, `fault`=0, `rd`=0, `req_ready`=0 while `reset`=1, 1 from the first cycle after release.
- Latency: request accepted in cycle T -> `rsp_valid` in cycle T+1+WAIT_STATES, exactly one cycle.
- Throughput: one request per WAIT_STATES+1 cycles; accept in RESP gives back-to-back operation (WAIT_STATES=0: one per cycle).
- Store followed immediately by load to same word: store commits at end of its RESP cycle; the load's response (≥1 cycle later) returns the new data.
- `req_valid` while `req_ready`=0: ignored, inputs need not be held by this block (pipeline holds them).
- Reset mid-operation (WAIT or RESP): pending request dropped, store in RESP not committed, no response issued.
- Inputs changing after accept have no effect on the in-flight access.

## Test plan
- WAIT_STATES=0: SW 0xDEADBEEF to 0x010, then LW 0x010 back-to-back -> responses at T+1 and T+2, second `rd`=0xDEADBEEF, `fault`=0.
- Byte/half lanes: SW 0x00000000 @0x020, SB 0x80 @0x023, SH 0x1234 @0x020 -> LW=0x80001234; LB @0x023=0xFFFFFF80; LBU=0x00000080; LH @0x022=0xFFFF8000; LHU @0x020=0x00001234.
- Misalignment: LW @0x021, SH @0x031, LH @0x033 -> each `fault`=1, `rd`=0; subsequent LW @0x030 shows word unchanged.
- Illegal: Funct3=011 load, Funct3=100 store, MemRead=MemWrite=1 -> `fault`=1, memory unchanged.
- WAIT_STATES=3: accept at T -> `req_ready`=0 T+1..T+3, `rsp_valid` only at T+4; `req_valid` held during WAIT not accepted early.
- Reset asserted during WAIT of an SW 0x11111111 @0x040 (old 0x22222222) -> no `rsp_valid`, all outputs 0, LW @0x040 after release returns 0x22222222.

Source files
------------

// File: rtl/datamemory_hs.sv
// Handshaked RV32I data memory: valid/ready request, programmable wait states,
// one-cycle response pulse with fault reporting, byte-lane stores.

module datamemory_hs_lane #(
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [7:0]    wdat,
    output logic [7:0]    rdat
);
    logic [7:0] mem [1<<IW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdat;
    end

    assign rdat = mem[addr];
endmodule

module datamemory_hs #(
    parameter int DM_ADDRESS  = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic                  fault
);
    localparam int IW        = DM_ADDRESS - 2;
    localparam int NUM_LANES = 4;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("datamemory_hs: DATA_W must be 32");
    end
    if (DM_ADDRESS < 3) begin : g_bad_addr_w
        $error("datamemory_hs: DM_ADDRESS must be at least 3");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("datamemory_hs: WAIT_STATES must be 0..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [DM_ADDRESS-1:0] a;
        logic [DATA_W-1:0]     wd;
        logic [2:0]            f3;
        logic                  ld;
        logic                  st;
        logic                  fault;
    } req_t;

    state_t state;
    logic [3:0] cnt;
    req_t q;

    logic accept, is_ld, is_st, misal, bad_ld, bad_st, acc_fault, we;
    logic [NUM_LANES-1:0] be;
    logic [NUM_LANES-1:0][7:0] wlane, word;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign req_ready = !reset && state != WAIT;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !reset && state == RESP;
    assign fault     = rsp_valid && q.fault;
    assign we        = rsp_valid && q.st && !q.fault;

    // Legality is decided once at accept so the in-flight access ignores later inputs.
    always_comb begin
        is_ld     = MemRead && !MemWrite;
        is_st     = MemWrite && !MemRead;
        misal     = (Funct3[1:0] == 2'b01 && a[0]) || (Funct3[1:0] == 2'b10 && a[1:0] != 2'b00);
        bad_ld    = Funct3 == 3'b011 || Funct3[2:1] == 2'b11;
        bad_st    = Funct3[2] || Funct3[1:0] == 2'b11;
        acc_fault = !(is_ld && !bad_ld && !misal) && !(is_st && !bad_st && !misal);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else if (accept) begin
            q     <= '{a: a, wd: wd, f3: Funct3, ld: is_ld, st: is_st, fault: acc_fault};
            cnt   <= 4'(WAIT_STATES);
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
        end else begin
            case (state)
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Narrow stores replicate their data across lanes; byte enables pick the target.
    always_comb begin
        be    = '0;
        wlane = q.wd;
        case (q.f3[1:0])
            2'b00: begin
                be[q.a[1:0]] = 1'b1;
                wlane        = {NUM_LANES{q.wd[7:0]}};
            end
            2'b01: begin
                be    = q.a[1] ? 4'b1100 : 4'b0011;
                wlane = {2{q.wd[15:0]}};
            end
            default: be = '1;
        endcase
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        datamemory_hs_lane #(.IW(IW)) u_lane (
            .clk  (clk),
            .we   (we && be[l]),
            .addr (q.a[DM_ADDRESS-1:2]),
            .wdat (wlane[l]),
            .rdat (word[l])
        );
    end

    // Read path is combinational from the array so a store committed on the
    // previous edge is visible to a back-to-back load.
    always_comb begin
        bsel = word[q.a[1:0]];
        hsel = q.a[1] ? {word[3], word[2]} : {word[1], word[0]};
        rd   = '0;
        if (rsp_valid && q.ld && !q.fault) begin
            case (q.f3)
                3'b000:  rd = {{24{bsel[7]}}, bsel};
                3'b001:  rd = {{16{hsel[15]}}, hsel};
                3'b010:  rd = word;
                3'b100:  rd = {24'b0, bsel};
                3'b101:  rd = {16'b0, hsel};
                default: rd = '0;
            endcase
        end
    end
endmodule
